// File: rtl/range_seq_driver.sv
// Buffers up to DEPTH samples, replays them as a go/stream/finish burst and checks the
// receiver's returned range against the locally tracked max-min of the burst.
module range_seq_driver #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       start,
  input  logic [DATA_W-1:0]          range_in,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_go,
  output logic                       tx_finish,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       done,
  output logic                       pass,
  output logic [DATA_W-1:0]          exp_range,
  output logic [7:0]                 fail_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StGo, StStream, StFinish, StCheck} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [CW-1:0]       count_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                pass_d, done_d, wr_do;
  logic [7:0]          fail_d;
  logic [DATA_W-1:0]   tx_data_d, sample;
  logic                tx_go_d, tx_finish_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count;
    idx_d       = idx_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pass_d      = pass;
    done_d      = 1'b0;
    fail_d      = fail_count;
    wr_do       = 1'b0;
    tx_data_d   = '0;
    tx_go_d     = 1'b0;
    tx_finish_d = 1'b0;
    sample      = '0;

    unique case (state_q)
      StIdle: begin
        // start has priority; a simultaneous write is dropped
        if (start && count != '0) begin
          state_d = StGo;
          pass_d  = 1'b0;
          idx_d   = '0;
        end else if (wr_en && count != DepthC) begin
          wr_do   = 1'b1;
          count_d = count + CW'(1);
        end
      end
      StGo: begin
        if (count == CW'(1)) begin
          state_d = StFinish;
        end else begin
          state_d = StStream;
          idx_d   = CW'(1);
        end
      end
      StStream: begin
        if (idx_q == count - CW'(1)) begin
          state_d = StFinish;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      StFinish: state_d = StCheck;
      StCheck: begin
        state_d = StIdle;
        pass_d  = (range_in == exp_range);
        done_d  = 1'b1;
        count_d = '0;
        if (!pass_d && fail_count != 8'hff) fail_d = fail_count + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    // Transmit outputs and range tracking follow the state being entered so they
    // line up with that state once registered.
    unique case (state_d)
      StGo: begin
        tx_data_d = mem_q[0];
        tx_go_d   = 1'b1;
        hi_d      = mem_q[0];
        lo_d      = mem_q[0];
      end
      StStream: begin
        sample    = mem_q[idx_d[IW-1:0]];
        tx_data_d = sample;
        if (sample > hi_q) hi_d = sample;
        if (sample < lo_q) lo_d = sample;
      end
      StFinish: begin
        tx_data_d   = mem_q[IW'(count - CW'(1))];
        tx_finish_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      count      <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      tx_data    <= '0;
      tx_go      <= 1'b0;
      tx_finish  <= 1'b0;
      busy       <= 1'b0;
      full       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      exp_range  <= '0;
      fail_count <= '0;
    end else begin
      state_q    <= state_d;
      count      <= count_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      tx_data    <= tx_data_d;
      tx_go      <= tx_go_d;
      tx_finish  <= tx_finish_d;
      busy       <= (state_d != StIdle);
      full       <= (count_d == DepthC);
      done       <= done_d;
      pass       <= pass_d;
      exp_range  <= hi_d - lo_d;
      fail_count <= fail_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_do) mem_q[count[IW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_range_seq_driver.sv
// Directed and randomized bench: each burst is predicted from the sample list alone
// (go, middle samples, finish, max-min range, pass/fail bookkeeping).
module tb_range_seq_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en, start;
  logic [9:0] wr_data, range_in;
  logic [9:0] tx_data, exp_range;
  logic       tx_go, tx_finish, busy, full, done, pass;
  logic [3:0] count;
  logic [7:0] fail_count;

  int tests = 0;
  int fails = 0;
  int fail_model = 0;
  int seq_q[$];

  range_seq_driver #(.DATA_W(10), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .range_in(range_in), .tx_data(tx_data), .tx_go(tx_go), .tx_finish(tx_finish),
    .busy(busy), .full(full), .count(count), .done(done), .pass(pass),
    .exp_range(exp_range), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_go"}, tx_go, 0);
    chk({tag, "_fin"}, tx_finish, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_cnt"}, count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_rng"}, exp_range, 0);
    chk({tag, "_fcnt"}, fail_count, 0);
  endtask

  task automatic load_seq();
    foreach (seq_q[i]) begin
      wr_en   = 1'b1;
      wr_data = 10'(seq_q[i]);
      tick();
      chk("load_cnt", count, i + 1);
      chk("load_full", full, int'(i + 1 == 8));
    end
    wr_en = 1'b0;
  endtask

  // rin_sel: -1 returns the correct range, -2 a random wrong one, else that value
  task automatic run_seq(input int rin_sel);
    int n, mx, mn, er, rin;
    n  = seq_q.size();
    mx = seq_q[0];
    mn = seq_q[0];
    foreach (seq_q[i]) begin
      if (seq_q[i] > mx) mx = seq_q[i];
      if (seq_q[i] < mn) mn = seq_q[i];
    end
    er = mx - mn;
    if (rin_sel == -1) rin = er;
    else if (rin_sel == -2) rin = (er + 1 + int'($urandom_range(0, 1022))) % 1024;
    else rin = rin_sel;

    start   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 10'($urandom);
    tick();
    start = 1'b0;
    chk("go_flag", tx_go, 1);
    chk("go_data", tx_data, seq_q[0]);
    chk("go_fin", tx_finish, 0);
    chk("go_busy", busy, 1);
    chk("go_pass_clr", pass, 0);
    chk("go_cnt", count, n);
    wr_en = 1'($urandom_range(0, 1));
    for (int i = 1; i < n; i++) begin
      tick();
      chk("str_data", tx_data, seq_q[i]);
      chk("str_go", tx_go, 0);
      chk("str_fin", tx_finish, 0);
    end
    tick();
    chk("fin_flag", tx_finish, 1);
    chk("fin_data", tx_data, seq_q[n-1]);
    chk("fin_go", tx_go, 0);
    chk("fin_rng", exp_range, er);
    chk("fin_cnt", count, n);
    wr_en = 1'b0;
    tick();
    chk("chk_tx", {22'd0, tx_data} | tx_go | tx_finish, 0);
    chk("chk_busy", busy, 1);
    chk("chk_done", done, 0);
    range_in = 10'(rin);
    tick();
    if (rin != er && fail_model < 255) fail_model++;
    chk("done_hi", done, 1);
    chk("done_busy", busy, 0);
    chk("done_pass", pass, int'(rin == er));
    chk("done_cnt", count, 0);
    chk("done_fcnt", fail_count, fail_model);
    range_in = 10'd0;
    tick();
    chk("done_lo", done, 0);
    chk("pass_hold", pass, int'(rin == er));
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; wr_data = '0; range_in = '0;
    #2;
    chk_all_zero("rst");
    #10 reset = 1'b1;

    seq_q = '{5, 12, 3, 9};  load_seq(); run_seq(9);
    seq_q = '{7};            load_seq(); run_seq(0);
    seq_q = '{5, 12, 3, 9};  load_seq(); run_seq(8);
    chk("fail_after_041", fail_count, 1);
    seq_q = '{5, 12, 3, 9};  load_seq(); run_seq(9);
    seq_q = '{0, 1023, 512}; load_seq(); run_seq(1023);

    // overfill: ninth write dropped
    seq_q = '{1, 2, 3, 4, 5, 6, 7, 8}; load_seq();
    wr_en = 1'b1; wr_data = 10'd99; tick(); wr_en = 1'b0;
    chk("ovf_cnt", count, 8);
    chk("ovf_full", full, 1);
    run_seq(-1);

    start = 1'b1; tick(); start = 1'b0;
    chk("empty_start_busy", busy, 0);
    chk("empty_start_go", tx_go, 0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      seq_q.delete();
      for (int k = 0; k < n; k++) seq_q.push_back(int'($urandom_range(0, 1023)));
      load_seq();
      run_seq(($urandom_range(0, 1) == 0) ? -1 : -2);
    end

    // reset in the middle of a stream
    seq_q = '{5, 12, 3, 9}; load_seq();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    fail_model = 0;
    load_seq();
    run_seq(9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
